// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: decodes mem_op, runs one req/ready bus
// transaction per legal load/store, stalls the pipeline meanwhile and returns extended load data.
module mem_access_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [4:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        illegal_o,
    output logic        bus_err_o,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_rdata_i
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [29:0] r_waddr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_discard;
    logic [31:0] r_rdata;

    logic        w_store, w_load, w_access, w_size_ok;
    logic        w_illegal, w_misalign, w_accept;
    logic [2:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_timeout;

    assign w_store  = mem_op_i[4];
    assign w_load   = mem_op_i[3];
    assign w_size   = mem_op_i[2:0];
    assign w_access = valid_i & ~flush_i & (w_load | w_store);

    // Encodings 011/110 are unassigned, so they are rejected for both directions.
    assign w_size_ok = w_load ? (w_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (w_size inside {3'b000, 3'b001, 3'b010});
    assign w_illegal  = w_access & ((w_load & w_store) | ~w_size_ok);
    assign w_misalign = w_access & ~w_illegal &
                        (((w_size[1:0] == 2'b01) & addr_i[0]) |
                         ((w_size[1:0] == 2'b10) & (addr_i[1:0] != 2'b00)));
    assign w_accept   = w_access & ~w_illegal & ~w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (w_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_off)
            2'b00:   w_byte = dm_rdata_i[7:0];
            2'b01:   w_byte = dm_rdata_i[15:8];
            2'b10:   w_byte = dm_rdata_i[23:16];
            default: w_byte = dm_rdata_i[31:24];
        endcase
        w_half = r_off[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
        case (r_size)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dm_rdata_i;
        endcase
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        stall_o       = 1'b0;
        illegal_o     = 1'b0;
        misalign_o    = 1'b0;
        dm_req_o      = 1'b0;
        bus_err_o     = 1'b0;
        rdata_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                illegal_o  = w_illegal;
                misalign_o = w_misalign;
                if (w_accept) begin
                    stall_o     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                dm_req_o = 1'b1;
                stall_o  = 1'b1;
                if (dm_ready_i)     w_state_nxt = S_DONE;
                else if (w_timeout) w_state_nxt = S_ERR;
            end
            S_DONE: begin
                rdata_valid_o = ~r_we & ~r_discard;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                bus_err_o   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus fields are forced low outside ACCESS so the memory never sees stale lanes.
    assign dm_we_o    = dm_req_o & r_we;
    assign dm_addr_o  = dm_req_o ? {r_waddr, 2'b00} : 32'd0;
    assign dm_be_o    = dm_req_o ? r_be : 4'd0;
    assign dm_wdata_o = dm_req_o ? r_wdata : 32'd0;
    assign rdata_o    = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_size    <= 3'd0;
            r_off     <= 2'd0;
            r_waddr   <= 30'd0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_discard <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_we      <= w_store;
                        r_size    <= w_size;
                        r_off     <= addr_i[1:0];
                        r_waddr   <= addr_i[31:2];
                        r_be      <= w_be;
                        r_wdata   <= w_wdata;
                        r_discard <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (flush_i) r_discard <= 1'b1;
                    if (dm_ready_i) begin
                        // A squashed load must not disturb the last delivered result.
                        if (!r_we && !r_discard && !flush_i) r_rdata <= w_ext;
                    end else if (!w_timeout) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
